// File: rtl/collision_arbiter_pkg.sv
// Shared definitions for the collision arbiter: direction mask layout and FSM encoding.
package collision_arbiter_pkg;

  localparam int unsigned COLL_W     = 4;
  localparam int unsigned COLL_UP    = 3;
  localparam int unsigned COLL_DOWN  = 2;
  localparam int unsigned COLL_RIGHT = 1;
  localparam int unsigned COLL_LEFT  = 0;

  typedef logic [COLL_W-1:0] coll_mask_t;

  // Fail-safe answer when the checker never responds: every direction blocked.
  localparam coll_mask_t COLL_ALL_BLOCKED = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

endpackage

// File: rtl/collision_arbiter_if.sv
// Bus between movement controllers, arbiter and collision checker.
//   req/req_x/req_y          : per-requester lookup request and packed candidate position
//   resp_valid/resp_collision: one-hot response strobe and direction mask back to requesters
//   chk_valid/chk_x/chk_y    : lookup strobe and query position to the checker
//   chk_done/chk_result      : checker result strobe and mask
// slave = arbiter view, master = controllers/checker view.
interface collision_arbiter_if
  import collision_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned POS_W   = 12
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*POS_W-1:0] req_x;
  logic [NUM_REQ*POS_W-1:0] req_y;
  logic [NUM_REQ-1:0]       resp_valid;
  coll_mask_t               resp_collision;
  logic                     chk_valid;
  logic [POS_W-1:0]         chk_x;
  logic [POS_W-1:0]         chk_y;
  logic                     chk_done;
  coll_mask_t               chk_result;

  modport slave (
    input  req, req_x, req_y, chk_done, chk_result,
    output resp_valid, resp_collision, chk_valid, chk_x, chk_y
  );

  modport master (
    output req, req_x, req_y, chk_done, chk_result,
    input  resp_valid, resp_collision, chk_valid, chk_x, chk_y
  );

endinterface

// File: rtl/collision_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   : request vector
//   last  : index granted last time; search starts at last+1 and wraps
//   idx   : winning index (0 when nothing found)
//   found : at least one request bit set
module collision_arbiter_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int unsigned IW = $clog2(N);

  int unsigned cand;

  // First set bit in the order last+1, last+2, ..., last (mod N).
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(last) + off) % N;
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/collision_arbiter.sv
// Round-robin arbiter sharing one block-collision checker among sprite controllers.
//   clk, rst    : system clock, synchronous active-high reset
//   bus (slave) : requester and checker handshakes, see collision_arbiter_if
//   busy        : high in every state except IDLE
//   timeout_err : one-cycle pulse, coincident with the response, when the checker timed out
module collision_arbiter
  import collision_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned POS_W   = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  collision_arbiter_if.slave  bus,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  coll_mask_t         mask_q, mask_d;
  logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
  logic               chk_valid_q, chk_valid_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  coll_mask_t         resp_coll_q, resp_coll_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [POS_W-1:0]   req_xs [NUM_REQ];
  logic [POS_W-1:0]   req_ys [NUM_REQ];

  // Unpack per-requester coordinates.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_xs[g] = bus.req_x[g*POS_W +: POS_W];
    assign req_ys[g] = bus.req_y[g*POS_W +: POS_W];
  end

  collision_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= IDX_W'(NUM_REQ-1);
      idx_q        <= '0;
      timer_q      <= '0;
      mask_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      chk_valid_q  <= 1'b0;
      resp_valid_q <= '0;
      resp_coll_q  <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      mask_q       <= mask_d;
      x_q          <= x_d;
      y_q          <= y_d;
      chk_valid_q  <= chk_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_coll_q  <= resp_coll_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next state; outputs are derived from the next state so they land with it.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    mask_d    = mask_q;
    x_d       = x_q;
    y_d       = y_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          x_d     = req_xs[pick_idx];
          y_d     = req_ys[pick_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (bus.chk_done) begin
          mask_d  = bus.chk_result;
          state_d = ST_RESPOND;
        end else if (timer_q == TMR_W'(TIMEOUT-1)) begin
          mask_d    = COLL_ALL_BLOCKED;
          timeout_d = 1'b1;
          state_d   = ST_RESPOND;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RESPOND: begin
        last_d  = idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    chk_valid_d  = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = '0;
    resp_coll_d  = '0;
    if (state_d == ST_RESPOND) begin
      resp_valid_d[idx_d] = 1'b1;
      resp_coll_d         = mask_d;
    end
  end

  assign bus.chk_valid      = chk_valid_q;
  assign bus.chk_x          = x_q;
  assign bus.chk_y          = y_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_collision = resp_coll_q;
  assign busy               = busy_q;
  assign timeout_err        = timeout_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Self-checking bench for collision_arbiter: vector table, corner sequences, random vs model.
module tb_collision_arbiter;

  localparam int NR = 4;
  localparam int PW = 12;
  localparam int TO = 15;
  localparam int NEVER = 99;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic timeout_err;

  collision_arbiter_if #(.NUM_REQ(NR), .POS_W(PW)) bus ();

  collision_arbiter #(.NUM_REQ(NR), .POS_W(PW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [PW-1:0] xa [NR];
  logic [PW-1:0] ya [NR];
  int model_last;

  typedef struct {
    logic [NR-1:0] rq;
    int            dly;
    logic [3:0]    res;
    int            exp_idx;
    logic [3:0]    exp_mask;
    logic          exp_to;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first set bit searching upward from last+1, wrapping.
  function automatic int rr_model(input logic [NR-1:0] rq, input int last);
    for (int off = 1; off <= NR; off++)
      if (rq[(last + off) % NR]) return (last + off) % NR;
    return -1;
  endfunction

  task automatic randomize_pos();
    for (int i = 0; i < NR; i++) begin
      xa[i] = PW'($urandom);
      ya[i] = PW'($urandom);
    end
  endtask

  // Drives one lookup; checker answers dly cycles into WAIT (NEVER = no answer).
  task automatic do_lookup(input logic [NR-1:0] rq, input int dly, input logic [3:0] res,
                           input bit drop, output logic [NR-1:0] o_rv, output logic [3:0] o_mask,
                           output logic o_to, output int o_lat, output int o_glitch,
                           output logic [PW-1:0] o_x, output logic [PW-1:0] o_y);
    int  t;
    bit  seen;
    o_rv = '0; o_mask = '0; o_to = 1'b0; o_lat = -1; o_glitch = 0; o_x = '0; o_y = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_x[i*PW +: PW] = xa[i];
      bus.req_y[i*PW +: PW] = ya[i];
    end
    bus.req = rq;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 6) begin
      tick();
      t++;
      seen = bus.chk_valid;
    end
    if (!seen) begin
      bus.req = '0;
      return;
    end
    o_x = bus.chk_x;
    o_y = bus.chk_y;
    tick();
    t++;
    if (drop) bus.req = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_x[i*PW +: PW] = xa[i] + PW'(100);
      bus.req_y[i*PW +: PW] = ya[i] + PW'(100);
    end
    seen = 1'b0;
    for (int k = 0; k < TO + 4 && !seen; k++) begin
      bus.chk_done   = (k == dly);
      bus.chk_result = res;
      if (bus.chk_x !== o_x || bus.chk_y !== o_y || bus.chk_valid !== 1'b0 || busy !== 1'b1)
        o_glitch++;
      tick();
      t++;
      bus.chk_done = 1'b0;
      if (bus.resp_valid != '0) begin
        seen   = 1'b1;
        o_rv   = bus.resp_valid;
        o_mask = bus.resp_collision;
        o_to   = timeout_err;
        if (bus.chk_x !== o_x) o_glitch++;
      end else if (bus.resp_collision != '0 || timeout_err) begin
        o_glitch++;
      end
    end
    if (seen) o_lat = t;
    bus.req = '0;
  endtask

  task automatic check_lookup(input string name, input logic [NR-1:0] rq, input int dly,
                              input logic [3:0] res, input bit drop, input bit fresh,
                              input int e_idx, input logic [3:0] e_mask, input logic e_to);
    logic [NR-1:0] rv;
    logic [3:0]    mask;
    logic          to;
    int            lat, glitch, e_lat;
    logic [PW-1:0] cx, cy;
    do_lookup(rq, dly, res, drop, rv, mask, to, lat, glitch, cx, cy);
    e_lat = (fresh ? 1 : 2) + 2 + ((dly < TO - 1) ? dly : TO - 1);
    check({name, ".resp_valid"}, 32'(rv), 32'(NR'(1) << e_idx));
    check({name, ".resp_collision"}, 32'(mask), 32'(e_mask));
    check({name, ".timeout_err"}, 32'(to), 32'(e_to));
    check({name, ".latency"}, 32'(lat), 32'(e_lat));
    check({name, ".chk_x"}, 32'(cx), 32'(xa[e_idx]));
    check({name, ".chk_y"}, 32'(cy), 32'(ya[e_idx]));
    check({name, ".glitches"}, 32'(glitch), 32'(0));
  endtask

  initial begin
    int bad;
    logic [NR-1:0] rq;
    int dly, e;
    logic [3:0] res;
    bit seen;

    tbl[0] = '{4'b0001, 1,     4'b0100, 0, 4'b0100, 1'b0};
    tbl[1] = '{4'b1111, 0,     4'b0011, 1, 4'b0011, 1'b0};
    tbl[2] = '{4'b1111, 0,     4'b1000, 2, 4'b1000, 1'b0};
    tbl[3] = '{4'b1111, 0,     4'b0000, 3, 4'b0000, 1'b0};
    tbl[4] = '{4'b1111, 0,     4'b0101, 0, 4'b0101, 1'b0};
    tbl[5] = '{4'b0010, NEVER, 4'b0000, 1, 4'b1111, 1'b1};
    tbl[6] = '{4'b0010, 14,    4'b0001, 1, 4'b0001, 1'b0};
    tbl[7] = '{4'b1001, 13,    4'b1010, 3, 4'b1010, 1'b0};
    tbl[8] = '{4'b1001, 2,     4'b0110, 0, 4'b0110, 1'b0};
    tbl[9] = '{4'b0110, 15,    4'b0111, 1, 4'b1111, 1'b1};

    rst = 1'b1;
    bus.req = '0; bus.req_x = '0; bus.req_y = '0;
    bus.chk_done = 1'b0; bus.chk_result = '0;
    repeat (3) tick();
    check("rst.resp_valid", 32'(bus.resp_valid), 0);
    check("rst.resp_collision", 32'(bus.resp_collision), 0);
    check("rst.chk_valid", 32'(bus.chk_valid), 0);
    check("rst.chk_x", 32'(bus.chk_x), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.timeout_err", 32'(timeout_err), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      randomize_pos();
      if (i == 0) begin
        xa[0] = PW'(482);
        ya[0] = PW'(648);
      end
      check_lookup($sformatf("tbl%0d", i), tbl[i].rq, tbl[i].dly, tbl[i].res, 1'b0, i == 0,
                   tbl[i].exp_idx, tbl[i].exp_mask, tbl[i].exp_to);
    end

    // Coordinates move 100 -> 200 during WAIT; query must keep the granted value.
    randomize_pos();
    xa[0] = PW'(100);
    check_lookup("stable", 4'b0001, 3, 4'b0010, 1'b0, 1'b0, 0, 4'b0010, 1'b0);

    // Stray checker strobes while idle must not produce anything.
    tick();
    bad = 0;
    bus.chk_done = 1'b1;
    bus.chk_result = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.chk_done = 1'b0;
      if (bus.resp_valid != '0 || busy || bus.chk_valid) bad++;
    end
    check("stray_done", 32'(bad), 0);

    // Reset in WAIT abandons the lookup; late chk_done is ignored.
    randomize_pos();
    bus.req = 4'b0100;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      seen = bus.chk_valid;
    end
    check("rstmid.issue_seen", 32'(seen), 1);
    repeat (3) tick();
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    check("rstmid.busy", 32'(busy), 0);
    bus.chk_done = 1'b1;
    bus.chk_result = 4'b0011;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      bus.chk_done = 1'b0;
      if (bus.resp_valid != '0 || busy) bad++;
    end
    check("rstmid.no_resp", 32'(bad), 0);
    randomize_pos();
    check_lookup("rstmid.next", 4'b1111, 0, 4'b1001, 1'b0, 1'b1, 0, 4'b1001, 1'b0);
    model_last = 0;

    // Random traffic against the round-robin / timeout model.
    for (int n = 0; n < 40; n++) begin
      randomize_pos();
      rq  = NR'($urandom_range(1, (1 << NR) - 1));
      dly = (($urandom % 6) == 0) ? NEVER : int'($urandom_range(0, TO + 1));
      res = 4'($urandom);
      e   = rr_model(rq, model_last);
      check_lookup($sformatf("rand%0d", n), rq, dly, res, ($urandom % 4) == 0, 1'b0, e,
                   (dly <= TO - 1) ? res : 4'b1111, dly > TO - 1);
      model_last = e;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/collision_arbiter.md
Name: collision_arbiter

Overview:
Shares one block-collision checker between several sprite movement controllers: hero, mirrored hero, and enemies. Each controller requests a collision lookup for a candidate position. The arbiter grants requests round-robin, issues each lookup to the checker, and returns the 4-bit direction mask (bit3 up, bit2 down, bit1 right, bit0 left) to the winning requester. It sits between the movement controllers and the collision checker, all in the system clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
POS_W, 12, pixel coordinate width
TIMEOUT, 15, checker-response timeout in clk cycles (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
req  in  NUM_REQ  lookup request per requester; level, held until own resp_valid
req_x  in  NUM_REQ*POS_W  packed candidate x per requester (slice i = requester i)
req_y  in  NUM_REQ*POS_W  packed candidate y per requester
resp_valid  out  NUM_REQ  one-cycle response strobe, one-hot
resp_collision  out  4  collision mask, valid when any resp_valid bit is set
chk_valid  out  1  one-cycle lookup strobe to checker
chk_x  out  POS_W  query x to checker, stable from chk_valid until response or timeout
chk_y  out  POS_W  query y to checker
chk_done  in  1  checker result strobe
chk_result  in  4  checker collision mask, valid with chk_done
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse when a lookup times out

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE, last_grant=NUM_REQ-1, timer=0, latched index=0.
  - All outputs 0.
  - rst mid-lookup abandons the lookup with no response; a late chk_done is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - If req!=0, select the first set bit searching upward from last_grant+1, modulo NUM_REQ.
  - Latch the winner index and its req_x/req_y slices into chk_x/chk_y; go to ISSUE.
  - If req==0, stay in IDLE.
- ISSUE:
  - chk_valid=1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT:
  - If chk_done: latch chk_result; go to RESPOND.
  - Else if timer==TIMEOUT-1: latch 4'b1111 (all directions blocked, fail-safe); pulse timeout_err; go to RESPOND.
  - Else timer++.
  - chk_done wins when it coincides with the timeout cycle.
- RESPOND:
  - resp_valid[idx]=1 and resp_collision=latched mask for this one cycle.
  - last_grant<=idx; go to IDLE.
  - resp_collision is 0 whenever resp_valid==0.
- chk_done seen in IDLE, ISSUE or RESPOND is ignored.
- Latency: req sampled in IDLE cycle T; chk_valid in cycle T+1; chk_done at earliest T+2; resp_valid in the cycle after chk_done. Minimum request-to-response latency is 3 cycles.
- Throughput: at most one lookup in flight; the next grant is decided in the IDLE cycle after RESPOND.
- Requester held in the same cycle as resp_valid: it is re-arbitrated normally. Round-robin prevents it winning twice in a row while any other req bit is set.
- A requester that drops req during ISSUE/WAIT still gets its lookup completed and its resp_valid pulse; it ignores the response.
- Query coordinates are latched at grant; later changes to req_x/req_y do not affect the lookup in flight.
- All outputs are registered or decoded from registered state only; there is no combinational path from input to output.

Decomposition:
- Shared package: collision mask bit indices (UP=3, DOWN=2, RIGHT=1, LEFT=0), COLL_ALL_BLOCKED=4'b1111, arbiter state encoding (2-bit).
- One sub-module: rr_pick. It is purely combinational: req vector plus last_grant in, winner index plus found flag out. It is reusable for the enemy-spawn scheduler.

Test Plan:
- Single request: req=4'b0001, x=482, y=648; checker answers chk_done with 4'b0100 two cycles after chk_valid -> chk_x=482, chk_y=648, chk_valid one cycle, resp_valid=4'b0001 with resp_collision=4'b0100, 4 cycles after req sampled.
- Round-robin: req=4'b1111 held, checker always answers after one cycle -> grant order 0,1,2,3,0; every resp_valid one-hot; no requester served twice in a row.
- Timeout: req=4'b0010, chk_done never asserted -> after 15 WAIT cycles: timeout_err pulse, resp_valid=4'b0010, resp_collision=4'b1111, state returns to IDLE.
- Done on timeout boundary: chk_done with 4'b0001 in the final WAIT cycle -> resp_collision=4'b0001, timeout_err stays 0.
- Reset mid-lookup: rst in WAIT, then chk_done pulses -> no resp_valid, busy=0, next grant goes to requester 0.
- Query stability: req_x changes from 100 to 200 during WAIT -> chk_x stays 100 until RESPOND; a stray chk_done in IDLE produces no response.
